tinker_fetch_queue: RTL and testbench
=====================================

// Module: tinker_fetch_queue
// PURPOSE
//  Instruction prefetch stage for the Tinker core; sits between unified byte memory and the
//  instruction decoder. Fetches 32-bit instructions over a req/ack port with variable latency.
//  Buffers up to DEPTH {pc, instr} pairs and hands them to decode over valid/ready.
//  Flushes and restarts on branch redirect; stops issuing fetches on halt.
// PARAMETERS
//  DEPTH     4        queue entries; power of two, >= 2
//  RESET_PC  64'h2000 first fetch address after reset
// PORTS
//  clk          in   1   clock
//  reset        in   1   asynchronous, active-high reset
//  mem_req      out  1   fetch request; held high until mem_ack
//  mem_addr     out  64  word address of the outstanding request, stable while mem_req=1
//  mem_ack      in   1   response valid this cycle; ignored when mem_req=0
//  mem_rdata    in   32  instruction word, already big-endian assembled, valid with mem_ack
//  instr_valid  out  1   queue head valid
//  instr        out  32  queue head instruction
//  instr_pc     out  64  queue head PC
//  instr_ready  in   1   decode consumes head when instr_valid && instr_ready
//  redirect     in   1   branch taken: flush and refetch
//  redirect_pc  in   64  new fetch PC; bits [1:0] forced to 0
//  halt         in   1   level; while 1, no new request is issued
// BEHAVIOUR
//  Reset values: mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
//  Reset internals: fetch_pc=RESET_PC, count=0, state=IDLE.
//  FSM states:
//   IDLE     no request outstanding.
//   WAIT     request outstanding.
//   DISCARD  request outstanding, response to be dropped.
//  Issue rule (IDLE, or WAIT on an ack cycle):
//   - Next cycle has mem_req=1, mem_addr=fetch_pc, state=WAIT, iff !halt && !redirect && count_next < DEPTH.
//   - Otherwise IDLE with mem_req=0.
//   - The first request is issued in the first clk edge after reset deasserts.
//  Ack in WAIT:
//   - Push {mem_addr, mem_rdata}; fetch_pc += 4 (wraps mod 2^64).
//   - Entry visible on instr_valid the next cycle.
//   - Zero-wait ack sustains 1 instruction/cycle.
//  Pop: head advances on instr_valid && instr_ready. Push and pop in the same cycle leave count unchanged.
//  Outputs: instr_valid = (count != 0); instr and instr_pc come from the head entry; hold when not consumed.
//  Redirect has priority over push and pop:
//   - Queue cleared (count=0, pointers reset) at the edge.
//   - fetch_pc = {redirect_pc[63:2],2'b00}.
//   - Head pop that cycle has no further effect.
//  Redirect per state:
//   - WAIT without ack: -> DISCARD. mem_req stays high with the old mem_addr (no abort).
//   - WAIT with ack same cycle: data dropped -> IDLE.
//   - IDLE: -> IDLE. Issue resumes the following cycle at the new PC.
//   - DISCARD: fetch_pc updated again. Stays DISCARD until ack, or goes to IDLE if ack is also present.
//  DISCARD + ack: data dropped, nothing pushed -> IDLE. Issue resumes next cycle per the issue rule.
//  Halt:
//   - Outstanding request completes and pushes normally; queue keeps draining.
//   - Deasserting halt resumes fetch at fetch_pc.
//  Full: count==DEPTH implies mem_req=0. Never push to a full queue (guaranteed by the issue rule).
//  Async reset mid-request: mem_req drops immediately and in-flight data is lost.
//  Memory must tolerate an abandoned request on reset.
// STRUCTURE
//  Package tinker_fetch_pkg:
//   - localparam RESET_PC_DEFAULT = 64'h2000
//   - typedef enum {IDLE, WAIT, DISCARD} fetch_state_t
//   - typedef struct packed {logic [63:0] pc; logic [31:0] instr;} fetch_entry_t
//  Sub-module tinker_sync_fifo:
//   - Parameterised DEPTH/WIDTH; async reset.
//   - Ports: push, pop, flush, count, head.
//   - Holds fetch_entry_t; flush beats push.
//  Top: FSM, fetch_pc, issue logic.
// TESTING
//  1. Reset, mem_ack combinational on mem_req, rdata=addr[31:0], ready=1:
//     instr_pc 0x2000,0x2004,0x2008 on consecutive cycles; instr equals the PC.
//  2. ready=0, DEPTH=4, zero-wait ack:
//     exactly 4 acks, then mem_req=0, instr_pc holds 0x2000; ready=1 resumes, PCs in order.
//  3. Ack latency 3, redirect_pc=0x3000 on the cycle after a request issues:
//     old response dropped, mem_addr stays until ack, first instr_pc seen is 0x3000.
//  4. Redirect on the same cycle as ack (redirect_pc=0x3003):
//     word not delivered; next mem_addr=0x3000.
//  5. halt=1 mid-stream:
//     outstanding request completes, no further mem_req, queue drains to instr_valid=0;
//     halt=0 fetches the next sequential PC.
//  6. reset pulsed while WAIT:
//     mem_req=0 and instr_valid=0 immediately; after release, mem_addr=0x2000.

Source files
------------

// File: rtl/tinker_fetch_pkg.sv
// Shared types and constants for the Tinker instruction prefetch stage.
package tinker_fetch_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h2000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/tinker_sync_fifo.sv
// Small synchronous FIFO with a combinational head and a flush that wins
// over push and pop. DEPTH must be a power of two so the pointers wrap freely.
module tinker_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Qualify requests so the FIFO never overruns or underruns itself.
    always_comb begin
        do_push = push && (count_q != DEPTH_C);
        do_pop  = pop && (count_q != '0);
    end

    // Storage, pointers and occupancy; flush clears occupancy only, data is left stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/tinker_fetch_queue.sv
// Instruction prefetch stage: issues word fetches over a req/ack port,
// buffers {pc, instr} pairs and hands them to decode over valid/ready.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  IDLE    | no request outstanding
//  WAIT    | request outstanding, response will be queued
//  DISCARD | request outstanding, response will be dropped
module tinker_fetch_queue
    import tinker_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        halt
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t  state_q;
    logic          mem_req_q;
    logic [63:0]   mem_addr_q;
    logic [63:0]   fetch_pc_q;
    logic [63:0]   fetch_pc_d;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          issue_ok;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    // Push/pop qualification, next fetch PC and the issue decision for this edge.
    always_comb begin
        push       = (state_q == WAIT) && mem_ack && !redirect;
        pop        = instr_valid && instr_ready && !redirect;
        push_entry = '{pc: mem_addr_q, instr: mem_rdata};

        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~64'h3;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
        end

        count_next = '0;
        if (!redirect) begin
            count_next = count + CW'(push) - CW'(pop);
        end

        // Gating on count_next guarantees a slot exists for every issued request.
        issue_ok = !halt && !redirect && (count_next < DEPTH_C);
    end

    // Fetch FSM with registered request outputs and the running fetch PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            case (state_q)
                IDLE: begin
                    if (issue_ok) begin
                        state_q    <= WAIT;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_d;
                    end else begin
                        mem_req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        if (issue_ok) begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= fetch_pc_d;
                        end else begin
                            state_q   <= IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end else if (redirect) begin
                        // Request cannot be aborted; keep it up and drop its data later.
                        state_q <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    tinker_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (push_entry),
        .count (count),
        .head  (head_entry)
    );

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = (count != '0);
    assign instr       = head_entry.instr;
    assign instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Directed bench for the prefetch queue with a latency-programmable memory
// responder and a scoreboard of expected {pc, instr} pairs.
module tb_tinker_fetch_queue;
    import tinker_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        halt;

    tinker_fetch_queue #(.DEPTH(4), .RESET_PC(64'h2000)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    fetch_entry_t expq[$];
    logic [63:0]  exp_addr;
    logic [63:0]  req_addr;
    logic         outst;
    logic         discard;
    int           lat_cnt;
    int           latency;
    int           acks;
    int           pops;
    int           new_reqs;
    logic [63:0]  first_pc;
    logic         first_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        expq.delete();
        exp_addr   = 64'h2000;
        req_addr   = 64'h0;
        outst      = 1'b0;
        discard    = 1'b0;
        lat_cnt    = 0;
        acks       = 0;
        pops       = 0;
        first_seen = 1'b0;
        first_pc   = 64'h0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        mem_ack  = 1'b0;
        redirect = 1'b0;
        halt     = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 64'h2000);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: observe, respond, update the scoreboard, then advance past the edge.
    task automatic tick();
        logic         ack;
        fetch_entry_t e;
        check("valid_vs_model", instr_valid, (expq.size() != 0));
        if (outst) begin
            check("req_hold", mem_req, 1);
            check("addr_hold", mem_addr, req_addr);
        end else if (mem_req) begin
            check("mem_addr", mem_addr, exp_addr);
            outst    = 1'b1;
            req_addr = exp_addr;
            lat_cnt  = latency;
            new_reqs++;
        end
        ack = outst && (lat_cnt == 0);
        if (outst && !ack) lat_cnt--;
        mem_ack   = ack;
        mem_rdata = req_addr[31:0];

        if (instr_valid && instr_ready && !redirect && expq.size() != 0) begin
            e = expq.pop_front();
            check("instr_pc", instr_pc, e.pc);
            check("instr", {32'h0, instr}, {32'h0, e.instr});
            if (!first_seen) begin
                first_seen = 1'b1;
                first_pc   = e.pc;
            end
            pops++;
        end
        if (redirect) begin
            expq.delete();
            exp_addr = redirect_pc & ~64'h3;
            if (outst && !ack) discard = 1'b1;
        end
        if (ack) begin
            if (!discard && !redirect) begin
                expq.push_back('{pc: req_addr, instr: req_addr[31:0]});
                exp_addr = req_addr + 64'd4;
                acks++;
            end
            outst   = 1'b0;
            discard = 1'b0;
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    initial begin
        int base;
        reset       = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        halt        = 1'b0;
        latency     = 0;
        new_reqs    = 0;
        model_clear();
        #1;

        // 1: streaming, one instruction per cycle
        do_reset();
        tick(); tick();
        check("t1_valid", instr_valid, 1);
        check("t1_pc0", instr_pc, 64'h2000);
        check("t1_instr0", {32'h0, instr}, 64'h2000);
        tick();
        check("t1_pc1", instr_pc, 64'h2004);
        tick();
        check("t1_pc2", instr_pc, 64'h2008);
        repeat (4) tick();

        // 2: decode stalled, queue fills to DEPTH
        do_reset();
        instr_ready = 1'b0;
        repeat (8) tick();
        check("t2_acks", acks, 4);
        check("t2_req_off", mem_req, 0);
        check("t2_head_pc", instr_pc, 64'h2000);
        instr_ready = 1'b1;
        repeat (10) tick();
        check("t2_first", first_pc, 64'h2000);

        // 3: redirect while a slow request is outstanding
        do_reset();
        latency = 3;
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h3000;
        tick();
        redirect = 1'b0;
        check("t3_addr_kept", mem_addr, 64'h2000);
        repeat (16) tick();
        check("t3_first_pc", first_pc, 64'h3000);
        check("t3_seen", first_seen, 1);

        // 4: redirect on the ack cycle, unaligned target
        do_reset();
        latency = 0;
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h3003;
        tick();
        redirect = 1'b0;
        check("t4_dropped", instr_valid, 0);
        tick();
        check("t4_req", mem_req, 1);
        check("t4_addr", mem_addr, 64'h3000);
        repeat (4) tick();
        check("t4_first_pc", first_pc, 64'h3000);

        // 5: halt mid-stream
        do_reset();
        latency = 2;
        repeat (5) tick();
        halt = 1'b1;
        base = new_reqs;
        repeat (6) tick();
        check("t5_no_new_req", new_reqs - base, 0);
        check("t5_req_off", mem_req, 0);
        check("t5_drained", instr_valid, 0);
        check("t5_pops", pops, 2);
        halt = 1'b0;
        tick();
        check("t5_resume_req", mem_req, 1);
        check("t5_resume_addr", mem_addr, 64'h2008);
        repeat (5) tick();

        // 6: reset in the middle of an outstanding request
        do_reset();
        latency     = 0;
        instr_ready = 1'b0;
        repeat (3) tick();
        check("t6_pre_valid", instr_valid, 1);
        check("t6_pre_req", mem_req, 1);
        #2;
        do_reset();
        instr_ready = 1'b1;
        tick();
        check("t6_req", mem_req, 1);
        check("t6_addr", mem_addr, 64'h2000);
        repeat (4) tick();
        check("t6_first_pc", first_pc, 64'h2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
